// File: rtl/onehot_scan_encoder.sv
// Request-vector to index encoder: emits the binary index of every set bit,
// lowest first, one beat per handshake. STRICT=1 gives single-beat one-hot encoding with an error flag.
//
// Handshakes: a transfer happens on the rising clk edge where valid && ready.
// A producer holds valid and its payload until that edge. Outputs come only
// from registers, so valid and ready never depend combinationally on each other.
module onehot_scan_encoder #(
  parameter int WIDTH  = 8,
  parameter int IDX_W  = $clog2(WIDTH),
  parameter bit STRICT = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_err,
  output logic             busy
);

  if (WIDTH < 2 || IDX_W < $clog2(WIDTH)) begin : g_bad_param
    $error("onehot_scan_encoder: WIDTH must be >= 2 and IDX_W >= clog2(WIDTH)");
  end

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   pend_low;
  logic [WIDTH-1:0]   in_low;
  logic               pend_multi;
  logic               in_multi;
  logic [IDX_W-1:0]   pend_idx;
  logic               emit;
  logic               last_beat;

  always_comb begin
    pend_low   = pending_q & (~pending_q + WIDTH'(1));
    in_low     = in_vec & (~in_vec + WIDTH'(1));
    pend_multi = (pending_q & (pending_q - WIDTH'(1))) != '0;
    in_multi   = (in_vec & (in_vec - WIDTH'(1))) != '0;
    // Descending scan so the lowest set bit wins; pending == 0 yields index 0.
    pend_idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) pend_idx = IDX_W'(i);
    end
    emit       = (state_q == EMIT);
    last_beat  = STRICT || !pend_multi;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          if (in_vec == '0) begin
            pending_d = '0;
            err_d     = 1'b1;
          end else if (STRICT && in_multi) begin
            pending_d = in_low;
            err_d     = 1'b1;
          end else begin
            pending_d = in_vec;
            err_d     = 1'b0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~pend_low;
          if (last_beat) begin
            state_d = IDLE;
            err_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = !emit;
  assign out_valid = emit;
  assign busy      = emit;
  assign out_idx   = emit ? pend_idx : '0;
  assign out_last  = emit && last_beat;
  assign out_err   = emit && err_q;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder: scan mode (WIDTH=8), strict mode
// (WIDTH=8) and scan mode with a non-power-of-two width (WIDTH=6).
module tb_onehot_scan_encoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid_a  [3];
  logic       in_ready_a  [3];
  logic [7:0] in_vec_a    [3];
  logic       out_valid_a [3];
  logic       out_ready_a [3];
  logic [2:0] out_idx_a   [3];
  logic       out_last_a  [3];
  logic       out_err_a   [3];
  logic       busy_a      [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onehot_scan_encoder #(.WIDTH(8), .IDX_W(3), .STRICT(1'b0)) u_scan8 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_vec(in_vec_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_idx(out_idx_a[0]),
    .out_last(out_last_a[0]), .out_err(out_err_a[0]), .busy(busy_a[0])
  );

  onehot_scan_encoder #(.WIDTH(8), .IDX_W(3), .STRICT(1'b1)) u_strict8 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_vec(in_vec_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_idx(out_idx_a[1]),
    .out_last(out_last_a[1]), .out_err(out_err_a[1]), .busy(busy_a[1])
  );

  onehot_scan_encoder #(.WIDTH(6), .IDX_W(3), .STRICT(1'b0)) u_scan6 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_vec(in_vec_a[2][5:0]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_idx(out_idx_a[2]),
    .out_last(out_last_a[2]), .out_err(out_err_a[2]), .busy(busy_a[2])
  );

  // One record per vector: target DUT, input, beat count, expected index
  // sequence (nibble k = index of beat k) and the error flag on every beat.
  typedef struct {
    int         d;
    logic [7:0] vec;
    int         n;
    logic [31:0] seq;
    logic       err;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] v);
    int b = 0;
    in_vec_a[d]   = v;
    in_valid_a[d] = 1'b1;
    while (!in_ready_a[d] && b < 20) begin
      step();
      b++;
    end
    check("accept_ready", 32'(in_ready_a[d]), 32'd1);
    step();
    in_valid_a[d] = 1'b0;
  endtask

  // Drains n beats; with stall=1 out_ready follows 1,0,0,1 per cycle and the
  // stall cycles also poke a new vector that must be ignored.
  task automatic collect(input int d, input logic [31:0] seq, input int n,
                         input logic err, input bit stall);
    int k = 0;
    int c = 0;
    bit rdy;
    bit prev_stall = 1'b0;
    logic [2:0] h_idx = '0;
    logic h_last = 1'b0;
    logic h_err = 1'b0;
    while (k < n && c < 200) begin
      if (!out_valid_a[d]) begin
        check("out_valid", 32'(out_valid_a[d]), 32'd1);
        break;
      end
      if (prev_stall) begin
        check("hold_idx", 32'(out_idx_a[d]), 32'(h_idx));
        check("hold_last", 32'(out_last_a[d]), 32'(h_last));
        check("hold_err", 32'(out_err_a[d]), 32'(h_err));
      end
      h_idx  = out_idx_a[d];
      h_last = out_last_a[d];
      h_err  = out_err_a[d];
      rdy = !stall || (c % 4 == 0) || (c % 4 == 3);
      out_ready_a[d] = rdy;
      if (rdy) begin
        check("idx", 32'(out_idx_a[d]), 32'(seq[4*k +: 4]));
        check("last", 32'(out_last_a[d]), 32'(k == n - 1));
        check("err", 32'(out_err_a[d]), 32'(err));
        k++;
      end else begin
        in_vec_a[d]   = 8'h0F;
        in_valid_a[d] = 1'b1;
        check("busy_in_ready", 32'(in_ready_a[d]), 32'd0);
      end
      step();
      out_ready_a[d] = 1'b0;
      in_valid_a[d]  = 1'b0;
      prev_stall = !rdy;
      c++;
    end
    check("beat_count", 32'(k), 32'(n));
    check("bubble_in_ready", 32'(in_ready_a[d]), 32'd1);
    check("bubble_out_valid", 32'(out_valid_a[d]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      in_vec_a[i]    = 8'h00;
      out_ready_a[i] = 1'b0;
    end

    tbl[0]  = '{0, 8'hA4, 3, 32'h752, 1'b0};
    tbl[1]  = '{0, 8'h00, 1, 32'h0, 1'b1};
    tbl[2]  = '{0, 8'h80, 1, 32'h7, 1'b0};
    tbl[3]  = '{0, 8'h01, 1, 32'h0, 1'b0};
    tbl[4]  = '{0, 8'h18, 2, 32'h43, 1'b0};
    tbl[5]  = '{1, 8'h10, 1, 32'h4, 1'b0};
    tbl[6]  = '{1, 8'h30, 1, 32'h4, 1'b1};
    tbl[7]  = '{1, 8'h00, 1, 32'h0, 1'b1};
    tbl[8]  = '{1, 8'h80, 1, 32'h7, 1'b0};
    tbl[9]  = '{1, 8'hFF, 1, 32'h0, 1'b1};
    tbl[10] = '{2, 8'h21, 2, 32'h50, 1'b0};
    tbl[11] = '{2, 8'h3F, 6, 32'h543210, 1'b0};
    tbl[12] = '{2, 8'h20, 1, 32'h5, 1'b0};
    tbl[13] = '{2, 8'h00, 1, 32'h0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 32'(in_ready_a[i]), 32'd1);
      check("rst_out_valid", 32'(out_valid_a[i]), 32'd0);
      check("rst_out_idx", 32'(out_idx_a[i]), 32'd0);
      check("rst_out_last", 32'(out_last_a[i]), 32'd0);
      check("rst_out_err", 32'(out_err_a[i]), 32'd0);
      check("rst_busy", 32'(busy_a[i]), 32'd0);
    end

    for (int t = 0; t < 14; t++) begin
      send(tbl[t].d, tbl[t].vec);
      check("busy_after_accept", 32'(busy_a[tbl[t].d]), 32'd1);
      collect(tbl[t].d, tbl[t].seq, tbl[t].n, tbl[t].err, 1'b0);
    end

    // All ones with a stalling consumer and upstream noise while busy.
    send(0, 8'hFF);
    collect(0, 32'h76543210, 8, 1'b0, 1'b1);

    // Reset mid-scan discards the pending vector.
    send(0, 8'hF0);
    check("pre_rst_idx", 32'(out_idx_a[0]), 32'd4);
    check("pre_rst_last", 32'(out_last_a[0]), 32'd0);
    out_ready_a[0] = 1'b1;
    step();
    out_ready_a[0] = 1'b0;
    check("pre_rst_idx2", 32'(out_idx_a[0]), 32'd5);
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check("midrst_in_ready", 32'(in_ready_a[0]), 32'd1);
    check("midrst_busy", 32'(busy_a[0]), 32'd0);
    check("midrst_out_idx", 32'(out_idx_a[0]), 32'd0);
    check("midrst_out_last", 32'(out_last_a[0]), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("postrst_out_valid", 32'(out_valid_a[0]), 32'd0);
    send(0, 8'h02);
    collect(0, 32'h1, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
